// File: rtl/div_sequencer_if.sv
// Request/response handshake between execute issue and writeback for the divider.
interface div_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;
   logic [4:0]      req_rd;
   logic            flush;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic [4:0]      resp_rd;

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_rd, flush, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_rd
   );

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_rd, flush, resp_ready,
      output req_ready, resp_valid, resp_data, resp_rd
   );
endinterface

// File: rtl/div_sequencer.sv
// Execute-stage controller for the shared 33-bit signed iterative divider.
module div_sequencer #(
   parameter int unsigned XLEN     = 32,
   parameter bit          REUSE_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   div_sequencer_if.slave  bus,
   output logic            busy,
   output logic [XLEN:0]   div_s1,
   output logic [XLEN:0]   div_s2,
   output logic            div_start,
   input  logic [XLEN:0]   div_quotient,
   input  logic [XLEN:0]   div_remainder,
   input  logic            div_ready
);
   localparam int unsigned DW = XLEN + 1;

   typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

   state_t          state, state_next;
   logic            resp_valid;
   logic [XLEN-1:0] resp_data, data_next;
   logic [4:0]      resp_rd, rd_next;
   logic [DW-1:0]   s1_next, s2_next;
   logic [1:0]      op_q, op_next;
   logic            cache_upd;

   logic            cache_valid;
   logic [XLEN-1:0] cache_rs1, cache_rs2, cache_quo, cache_rem;
   logic            cache_uns;

   logic            accept, hit;
   logic [DW-1:0]   ext1, ext2;
   logic            unused_msb;

   // The divider's top result bit never reaches a 32-bit result.
   assign unused_msb = ^{div_quotient[XLEN], div_remainder[XLEN]};

   assign bus.req_ready  = (state == IDLE) && !bus.flush;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_data  = resp_data;
   assign bus.resp_rd    = resp_rd;

   assign accept = bus.req_valid && bus.req_ready;
   // Sign-extend for DIV/REM, zero-extend for the unsigned forms.
   assign ext1   = {~bus.req_op[0] & bus.req_rs1[XLEN-1], bus.req_rs1};
   assign ext2   = {~bus.req_op[0] & bus.req_rs2[XLEN-1], bus.req_rs2};
   assign hit    = REUSE_EN && cache_valid && (cache_rs1 == bus.req_rs1) &&
                   (cache_rs2 == bus.req_rs2) && (cache_uns == bus.req_op[0]);

   // Next-state and next register values.
   always_comb begin
      state_next = state;
      data_next  = resp_data;
      rd_next    = resp_rd;
      s1_next    = div_s1;
      s2_next    = div_s2;
      op_next    = op_q;
      cache_upd  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               rd_next = bus.req_rd;
               op_next = bus.req_op;
               if (bus.req_rs2 == '0) begin
                  data_next  = bus.req_op[1] ? bus.req_rs1 : '1;
                  state_next = RESP;
               end else if (hit) begin
                  data_next  = bus.req_op[1] ? cache_rem : cache_quo;
                  state_next = RESP;
               end else begin
                  s1_next    = ext1;
                  s2_next    = ext2;
                  state_next = START;
               end
            end
         end
         START: state_next = bus.flush ? DRAIN : WAIT;
         WAIT: begin
            if (bus.flush) begin
               state_next = DRAIN;
               if (div_ready) begin
                  cache_upd  = 1'b1;
                  state_next = IDLE;
               end
            end else if (div_ready) begin
               cache_upd  = 1'b1;
               data_next  = op_q[1] ? div_remainder[XLEN-1:0] : div_quotient[XLEN-1:0];
               state_next = RESP;
            end
         end
         DRAIN: begin
            if (div_ready) begin
               cache_upd  = 1'b1;
               state_next = IDLE;
            end
         end
         RESP: begin
            if (bus.flush || bus.resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         div_s1     <= '0;
         div_s2     <= '0;
         div_start  <= 1'b0;
         busy       <= 1'b0;
         op_q       <= '0;
      end else begin
         state      <= state_next;
         resp_valid <= (state_next == RESP);
         resp_data  <= data_next;
         resp_rd    <= rd_next;
         div_s1     <= s1_next;
         div_s2     <= s2_next;
         div_start  <= (state_next == START);
         busy       <= (state_next != IDLE);
         op_q       <= op_next;
      end
   end

   // Last-result cache, refilled by every completed divider run including drained ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_rs1   <= '0;
         cache_rs2   <= '0;
         cache_uns   <= 1'b0;
         cache_quo   <= '0;
         cache_rem   <= '0;
      end else if (cache_upd) begin
         cache_valid <= 1'b1;
         cache_rs1   <= div_s1[XLEN-1:0];
         cache_rs2   <= div_s2[XLEN-1:0];
         cache_uns   <= op_q[0];
         cache_quo   <= div_quotient[XLEN-1:0];
         cache_rem   <= div_remainder[XLEN-1:0];
      end
   end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural 36-cycle divider.
module tb_div_sequencer;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            busy, div_start, div_ready;
   logic [XLEN:0]   div_s1, div_s2, div_quotient, div_remainder;

   div_sequencer_if #(.XLEN(XLEN)) bus ();

   div_sequencer #(.XLEN(XLEN), .REUSE_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
      .div_s1(div_s1), .div_s2(div_s2), .div_start(div_start),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_ready(div_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_start = 0;
   int   t_acc   = 0;
   int   t_prev  = 0;
   int   dcnt;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (div_start) n_start <= n_start + 1;

   // Divider: start sampled in cycle 1, completion pulse in cycle 36.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt          <= 0;
         div_ready     <= 1'b0;
         div_quotient  <= '0;
         div_remainder <= '0;
      end else begin
         div_ready <= 1'b0;
         if (div_start) dcnt <= 1;
         else if (dcnt == 34) begin
            dcnt          <= 0;
            div_ready     <= 1'b1;
            div_quotient  <= 33'($signed(div_s1) / $signed(div_s2));
            div_remainder <= 33'($signed(div_s1) % $signed(div_s2));
         end else if (dcnt != 0) dcnt <= dcnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one request at a negedge; returns at the negedge of cycle 1.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rs1   = a;
      bus.req_rs2   = b;
      bus.req_rd    = rd;
      chk("req_ready_at_send", 64'(bus.req_ready), 64'd1);
      t_prev = t_acc;
      t_acc  = cyc;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] rd);
      exp_t e;
      e.data = d;
      e.rd   = rd;
      sb.push_back(e);
   endtask

   // Wait (bounded) for resp_valid, compare latency and scoreboard head, then consume.
   task automatic wait_resp(input string tag, input int lat);
      int   k = 0;
      exp_t e;
      while (!bus.resp_valid && k < 80) begin
         @(negedge clk);
         k++;
      end
      if (!bus.resp_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
      else begin
         chk({tag, "_lat"}, 64'(cyc - t_acc), 64'(lat));
         if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
         else begin
            e = sb.pop_front();
            chk({tag, "_data"}, 64'(bus.resp_data), 64'(e.data));
            chk({tag, "_rd"}, 64'(bus.resp_rd), 64'(e.rd));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int          k;
      int          s0;
      logic        saw_rdy, saw_resp;
      logic [31:0] hd;
      logic [4:0]  hr;

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_op     = 2'b00;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.req_rd     = '0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
      chk("rst_div_s1", 64'(div_s1), 64'd0);
      chk("rst_div_start", 64'(div_start), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      bus.flush = 1'b1;
      #1;
      chk("rst_req_ready_flush", 64'(bus.req_ready), 64'd0);
      bus.flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // DIV -7 / 2 through the divider.
      push(32'hFFFFFFFD, 5'd3);
      send(2'b00, 32'hFFFFFFF9, 32'h2, 5'd3);
      chk("div1_start", 64'(div_start), 64'd1);
      chk("div1_s1", 64'(div_s1), 64'h1FFFFFFF9);
      chk("div1_s2", 64'(div_s2), 64'h000000002);
      chk("div1_busy", 64'(busy), 64'd1);
      wait_resp("div1", 37);

      // REM with same operands hits the cache.
      s0 = n_start;
      push(32'hFFFFFFFF, 5'd4);
      send(2'b10, 32'hFFFFFFF9, 32'h2, 5'd4);
      chk("thru_div", 64'(t_acc - t_prev), 64'd38);
      wait_resp("rem_hit", 1);
      chk("rem_hit_nostart", 64'(n_start), 64'(s0));

      // DIVU 0xFFFFFFFF / 2 then DIV with same operands must miss.
      push(32'h7FFFFFFF, 5'd5);
      send(2'b01, 32'hFFFFFFFF, 32'h2, 5'd5);
      chk("divu_s1", 64'(div_s1), 64'h0FFFFFFFF);
      wait_resp("divu", 37);
      push(32'h00000000, 5'd6);
      send(2'b00, 32'hFFFFFFFF, 32'h2, 5'd6);
      chk("div_miss_start", 64'(div_start), 64'd1);
      chk("div_miss_s1", 64'(div_s1), 64'h1FFFFFFFF);
      wait_resp("div_miss", 37);

      // Most-negative / -1.
      push(32'h80000000, 5'd7);
      send(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd7);
      wait_resp("ovf_div", 37);
      push(32'h00000000, 5'd8);
      send(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd8);
      wait_resp("ovf_rem", 1);

      // Divide by zero.
      s0 = n_start;
      push(32'hFFFFFFFF, 5'd9);
      send(2'b01, 32'd5, 32'd0, 5'd9);
      wait_resp("divu_z", 1);
      push(32'hFFFFFFFB, 5'd10);
      send(2'b10, 32'hFFFFFFFB, 32'd0, 5'd10);
      chk("thru_fast", 64'(t_acc - t_prev), 64'd2);
      wait_resp("rem_z", 1);
      chk("zero_nostart", 64'(n_start), 64'(s0));

      // Flush in cycle 10 of a divider op.
      s0 = n_start;
      send(2'b00, 32'd100, 32'd7, 5'd11);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      saw_rdy  = 1'b0;
      saw_resp = 1'b0;
      k = 0;
      while (!div_ready && k < 80) begin
         saw_rdy  = saw_rdy | bus.req_ready;
         saw_resp = saw_resp | bus.resp_valid;
         @(negedge clk);
         k++;
      end
      chk("flush_div_ready_seen", 64'(div_ready), 64'd1);
      chk("flush_ready_low", 64'(saw_rdy | bus.req_ready), 64'd0);
      chk("flush_no_resp", 64'(saw_resp | bus.resp_valid), 64'd0);
      chk("flush_s1_held", 64'(div_s1), 64'd100);
      @(negedge clk);
      chk("flush_ready_after", 64'(bus.req_ready), 64'd1);
      chk("flush_resp_after", 64'(bus.resp_valid), 64'd0);
      chk("flush_one_start", 64'(n_start), 64'(s0 + 1));
      push(32'd14, 5'd12);
      send(2'b00, 32'd100, 32'd7, 5'd12);
      wait_resp("flush_hit", 1);
      chk("flush_hit_nostart", 64'(n_start), 64'(s0 + 1));

      // Backpressure: response held stable for 5 cycles.
      bus.resp_ready = 1'b0;
      push(32'd2, 5'd13);
      send(2'b10, 32'd100, 32'd7, 5'd13);
      hd = 32'd2;
      hr = 5'd13;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(bus.resp_valid), 64'd1);
         chk("bp_data", 64'(bus.resp_data), 64'(hd));
         chk("bp_rd", 64'(bus.resp_rd), 64'(hr));
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      wait_resp("bp", 6);

      // Reset in cycle 20 of a divider op; cache must be cleared.
      send(2'b00, 32'd1000, 32'd3, 5'd14);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("mid_rst_resp_data", 64'(bus.resp_data), 64'd0);
      chk("mid_rst_resp_rd", 64'(bus.resp_rd), 64'd0);
      chk("mid_rst_div_s1", 64'(div_s1), 64'd0);
      chk("mid_rst_div_s2", 64'(div_s2), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(32'd14, 5'd15);
      send(2'b00, 32'd100, 32'd7, 5'd15);
      chk("post_rst_start", 64'(div_start), 64'd1);
      wait_resp("post_rst", 37);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
